debug_dump_sequencer: RTL and testbench



---
 rtl/debug_dump_sequencer.sv | 160 ++++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer
// Streams a latched pipeline snapshot to the UART TX FIFO as a framed byte
// sequence: HEADER_BYTE, word count, data bytes (word 0 first, MSB first within
// a word) and, when DUMP_CHECKSUM_EN is defined, an XOR checksum byte.
//
// Optional feature macro: DUMP_CHECKSUM_EN (CHECK state + checksum byte).
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous active-high reset
//   start              dump request, honoured only in IDLE
//   abort              synchronous cancel of an in-progress frame
//   snapshotData       flattened snapshot, word 0 in bits [31:0]
//   uartTxFull         TX FIFO full, blocks writes
//   dataToUartOutFifo  byte presented to the FIFO (0 when not writing)
//   writeFifoFlag      write strobe, same cycle as the byte
//   busy               high in HEADER..CHECK
//   done               one-cycle pulse in the DONE state
module debug_dump_sequencer #(
   parameter int unsigned NUM_WORDS   = 8,
   parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [NUM_WORDS*32-1:0] snapshotData,
   input  logic                    uartTxFull,
   output logic [7:0]              dataToUartOutFifo,
   output logic                    writeFifoFlag,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned NUM_BYTES  = NUM_WORDS * 4;
   localparam int unsigned IDX_W      = $clog2(NUM_BYTES);
   localparam int unsigned POS_W      = IDX_W + 3;
   localparam int unsigned DATA_W     = NUM_WORDS * 32;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
   localparam logic [7:0]       COUNT_BYTE = 8'(NUM_WORDS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      COUNT  = 3'd2,
      DATA   = 3'd3,
`ifdef DUMP_CHECKSUM_EN
      CHECK  = 3'd4,
`endif
      DONE   = 3'd5
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] snapLatch;
   logic [IDX_W-1:0]  byteIdx;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]        checksum;
`endif

   logic [POS_W-1:0]  bitPos;
   logic [7:0]        curByte;
   logic              sending;
   logic              issue;

   // Inverting the two low index bits walks each word MSB first.
   assign bitPos = POS_W'({byteIdx ^ IDX_W'(3), 3'b000});

   // Byte offered in the current state.
   always_comb begin
      curByte = 8'h00;
      sending = 1'b0;
      case (state)
         HEADER: begin curByte = HEADER_BYTE;             sending = 1'b1; end
         COUNT:  begin curByte = COUNT_BYTE;              sending = 1'b1; end
         DATA:   begin curByte = snapLatch[bitPos +: 8];  sending = 1'b1; end
`ifdef DUMP_CHECKSUM_EN
         CHECK:  begin curByte = checksum;                sending = 1'b1; end
`endif
         default: ;
      endcase
   end

   // Write issues in the same cycle the FIFO has room; abort suppresses it.
   assign issue             = sending && !uartTxFull && !abort;
   assign writeFifoFlag     = issue;
   assign dataToUartOutFifo = issue ? curByte : 8'h00;

   // Frame sequencer with registered busy/done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         snapLatch <= '0;
         byteIdx   <= '0;
`ifdef DUMP_CHECKSUM_EN
         checksum  <= 8'h00;
`endif
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  snapLatch <= snapshotData;
                  byteIdx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                  checksum  <= 8'h00;
`endif
                  busy      <= 1'b1;
                  state     <= HEADER;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (!uartTxFull) begin
                  case (state)
                     HEADER: state <= COUNT;
                     COUNT: begin
`ifdef DUMP_CHECKSUM_EN
                        checksum <= checksum ^ COUNT_BYTE;
`endif
                        state    <= DATA;
                     end
                     DATA: begin
`ifdef DUMP_CHECKSUM_EN
                        checksum <= checksum ^ curByte;
`endif
                        if (byteIdx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                           state <= CHECK;
`else
                           busy  <= 1'b0;
                           done  <= 1'b1;
                           state <= DONE;
`endif
                        end else begin
                           byteIdx <= byteIdx + IDX_W'(1);
                        end
                     end
`ifdef DUMP_CHECKSUM_EN
                     CHECK: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                     end
`endif
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Testbench for debug_dump_sequencer (NUM_WORDS=2). A frame-level model
// predicts, cycle by cycle, which byte the FIFO should receive given the
// uartTxFull pattern, plus busy/done timing.
module tb_debug_dump_sequencer;

   localparam int unsigned NW = 2;
   localparam int unsigned NB = NW * 4;
`ifdef DUMP_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = 2 + NB + 1;
`else
   localparam int unsigned FRAME_LEN = 2 + NB;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [NW*32-1:0] snapshotData;
   logic             uartTxFull;
   logic [7:0]       dataToUartOutFifo;
   logic             writeFifoFlag;
   logic             busy;
   logic             done;

   int nChecks = 0;
   int nFails  = 0;

   logic [7:0] expBytes [FRAME_LEN];

   typedef struct {
      logic [NW*32-1:0] snap;
      logic [NW*32-1:0] scramble;
      int               stallAt;
      int               stallLen;
      bit               randFull;
      bit               startSpam;
      bit               fixedChk;
      logic [7:0]       expChk;
   } vec_t;

   debug_dump_sequencer #(
      .NUM_WORDS   (NW),
      .HEADER_BYTE (8'hA5)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .snapshotData      (snapshotData),
      .uartTxFull        (uartTxFull),
      .dataToUartOutFifo (dataToUartOutFifo),
      .writeFifoFlag     (writeFifoFlag),
      .busy              (busy),
      .done              (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Expected frame built straight from the frame format.
   task automatic buildModel(input logic [NW*32-1:0] snap);
      logic [7:0]  chk;
      logic [31:0] word;
      logic [7:0]  b;
      expBytes[0] = 8'hA5;
      expBytes[1] = 8'(NW);
      chk = 8'(NW);
      for (int k = 0; k < int'(NB); k++) begin
         word = 32'(snap >> (32 * (k / 4)));
         b    = 8'(word >> (8 * (3 - (k % 4))));
         expBytes[2 + k] = b;
         chk = chk ^ b;
      end
`ifdef DUMP_CHECKSUM_EN
      expBytes[FRAME_LEN - 1] = chk;
`endif
   endtask

   task automatic checkIdle(input string tag);
      @(negedge clock);
      check({tag, " idle write"}, 32'(writeFifoFlag), 32'd0);
      check({tag, " idle busy"},  32'(busy),          32'd0);
      check({tag, " idle done"},  32'(done),          32'd0);
      nextCycle();
   endtask

   task automatic runFrame(input vec_t v, input string tag);
      int sent;
      int stalled;
      bit doneSeen;
      bit full;
      bit expWr;
      sent = 0; stalled = 0; doneSeen = 1'b0;
      buildModel(v.snap);
`ifdef DUMP_CHECKSUM_EN
      if (v.fixedChk) expBytes[FRAME_LEN - 1] = v.expChk;
`endif
      snapshotData = v.snap;
      start = 1'b1; abort = 1'b0; uartTxFull = 1'b0;
      @(negedge clock);
      check({tag, " start busy"}, 32'(busy), 32'd0);
      nextCycle();
      start = 1'b0;
      snapshotData = v.scramble;
      for (int c = 1; c < int'(FRAME_LEN) * 20 && !doneSeen; c++) begin
         if (v.randFull) full = ($urandom_range(0, 2) == 0);
         else            full = (sent == v.stallAt) && (stalled < v.stallLen);
         if (full) stalled++;
         uartTxFull = full;
         if (v.startSpam) start = (c == 5) || (sent == int'(FRAME_LEN));
         expWr = !full && (sent < int'(FRAME_LEN));
         @(negedge clock);
         check({tag, " write"}, 32'(writeFifoFlag), 32'(expWr));
         if (expWr) check({tag, " byte"}, 32'(dataToUartOutFifo), 32'(expBytes[sent]));
         check({tag, " busy"}, 32'(busy), 32'(sent < int'(FRAME_LEN)));
         check({tag, " done"}, 32'(done), 32'(sent == int'(FRAME_LEN)));
         if (sent == int'(FRAME_LEN)) doneSeen = 1'b1;
         if (expWr) sent++;
         nextCycle();
      end
      if (!doneSeen) check({tag, " frame timeout"}, 32'd0, 32'd1);
      start = 1'b0;
      uartTxFull = 1'b0;
      checkIdle(tag);
      if (v.startSpam) begin
         checkIdle(tag);
         checkIdle(tag);
      end
   endtask

   initial begin
      vec_t vecs [6];
      vec_t rv;
      vecs[0] = '{{32'h9ABCDEF0, 32'h12345678}, {64{1'b1}}, -1, 0, 1'b0, 1'b0, 1'b1, 8'h02};
      vecs[1] = '{{32'h9ABCDEF0, 32'h12345678}, {32'h9ABCDEF0, 32'h12345678}, 4, 3, 1'b0, 1'b0, 1'b1, 8'h02};
      vecs[2] = '{64'h0, 64'hDEADBEEF_CAFEF00D, -1, 0, 1'b0, 1'b0, 1'b1, 8'h02};
      vecs[3] = '{{32'h00000001, 32'hFFFFFFFF}, 64'h0, 0, 2, 1'b0, 1'b0, 1'b1, 8'h03};
      vecs[4] = '{{32'h05060708, 32'h01020304}, 64'h0, -1, 0, 1'b0, 1'b1, 1'b1, 8'h0A};
      vecs[5] = '{{32'h9ABCDEF0, 32'h12345678}, 64'h0, 9, 4, 1'b0, 1'b0, 1'b1, 8'h02};

      reset = 1'b1; start = 1'b0; abort = 1'b0; uartTxFull = 1'b0; snapshotData = '0;
      #12;
      check("reset write", 32'(writeFifoFlag),     32'd0);
      check("reset data",  32'(dataToUartOutFifo), 32'd0);
      check("reset busy",  32'(busy),              32'd0);
      check("reset done",  32'(done),              32'd0);
      nextCycle();
      reset = 1'b0;
      checkIdle("post reset");

      for (int i = 0; i < 6; i++) runFrame(vecs[i], $sformatf("vec%0d", i));

      // Abort while the COUNT byte is on offer.
      snapshotData = vecs[0].snap;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      @(negedge clock);
      check("abort header write", 32'(writeFifoFlag),     32'd1);
      check("abort header byte",  32'(dataToUartOutFifo), 32'hA5);
      nextCycle();
      abort = 1'b1;
      @(negedge clock);
      check("abort cycle write", 32'(writeFifoFlag), 32'd0);
      check("abort cycle busy",  32'(busy),          32'd1);
      nextCycle();
      abort = 1'b0;
      checkIdle("after abort");
      checkIdle("after abort");
      runFrame(vecs[0], "post abort");

      // abort and start together in IDLE: nothing starts.
      start = 1'b1; abort = 1'b1;
      nextCycle();
      start = 1'b0; abort = 1'b0;
      checkIdle("abort+start");
      checkIdle("abort+start");

      // Reset asserted while a data byte is being written.
      snapshotData = vecs[0].snap;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      for (int c = 1; c < 5; c++) nextCycle();
      check("pre reset write", 32'(writeFifoFlag), 32'd1);
      reset = 1'b1;
      #1;
      check("mid reset write", 32'(writeFifoFlag),     32'd0);
      check("mid reset data",  32'(dataToUartOutFifo), 32'd0);
      check("mid reset busy",  32'(busy),              32'd0);
      check("mid reset done",  32'(done),              32'd0);
      nextCycle();
      reset = 1'b0;
      checkIdle("after reset");
      runFrame(vecs[0], "post reset");

      // Random snapshots under random backpressure.
      for (int i = 0; i < 20; i++) begin
         rv.snap      = {$urandom, $urandom};
         rv.scramble  = {$urandom, $urandom};
         rv.stallAt   = -1;
         rv.stallLen  = 0;
         rv.randFull  = 1'b1;
         rv.startSpam = ($urandom_range(0, 3) == 0);
         rv.fixedChk  = 1'b0;
         rv.expChk    = 8'h00;
         runFrame(rv, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
